// File: rtl/jtcop_obj_linebuf.sv
// Double-buffered object line buffer: renderer writes one bank while the other is scanned out and erased.
// Optional JTCOP_OBJ_FIRSTWIN_EN: first opaque pixel wins; default build is last-write-wins.
module jtcop_obj_linebuf #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [8:0]    hdump,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_we,
  output logic          buf_rdy,
  output logic          line,
  output logic [DW-1:0] obj_pxl
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_q;
  logic [AW-1:0]          init_cnt_q;
  logic                   line_q;
  logic                   lhbl_q;
  logic [DW-1:0]          obj_pxl_q;
  logic                   s1_vld_q;
  logic                   s1_bank_q;
  logic [AW-1:0]          s1_addr_q;
  logic [DW-1:0]          s1_data_q;
  logic                   er_vld_q;
  logic                   er_bank_q;
  logic [AW-1:0]          er_addr_q;
  logic [1:0][DW-1:0]     bank_rd;
  logic [DW-1:0]          disp_rd;
  logic                   s0_take;
  logic                   s1_commit;
  logic                   unused_hdump;

  assign unused_hdump = ^hdump;
  assign buf_rdy      = (state_q == RUN);
  assign line         = line_q;
  assign obj_pxl      = obj_pxl_q;
  assign s0_take      = buf_we & buf_rdy & (buf_data[3:0] != 4'd0);
  assign disp_rd      = line_q ? bank_rd[0] : bank_rd[1];

`ifdef JTCOP_OBJ_FIRSTWIN_EN
  logic s1_occ_q;
  logic s0_occ;

  // A stage-1 write still in flight to the same pixel leaves it opaque whether or not it commits.
  always_comb begin
    s0_occ = (bank_rd[line_q][3:0] != 4'd0);
    if (s1_vld_q && (s1_bank_q == line_q) && (s1_addr_q == buf_addr)) s0_occ = 1'b1;
  end
  assign s1_commit = s1_vld_q & ~s1_occ_q & ~rst;
`else
  assign s1_commit = s1_vld_q & ~rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      line_q     <= 1'b0;
      lhbl_q     <= 1'b1;
      obj_pxl_q  <= '0;
      s1_vld_q   <= 1'b0;
      er_vld_q   <= 1'b0;
    end else begin
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (&init_cnt_q) state_q <= RUN;
      end
      s1_vld_q <= s0_take;
      er_vld_q <= 1'b0;
      if (pxl_cen) begin
        lhbl_q <= LHBL;
        if (LHBL && state_q == RUN) begin
          obj_pxl_q <= disp_rd;
          er_vld_q  <= 1'b1;
          er_addr_q <= hdump[AW-1:0];
          er_bank_q <= ~line_q;
        end else begin
          obj_pxl_q <= '0;
        end
        // Stage 1 latched its bank before this edge, so an in-flight write lands in the old bank.
        if (lhbl_q && !LHBL) line_q <= ~line_q;
      end
    end
    if (s0_take) begin
      s1_addr_q <= buf_addr;
      s1_data_q <= buf_data;
      s1_bank_q <= line_q;
`ifdef JTCOP_OBJ_FIRSTWIN_EN
      s1_occ_q  <= s0_occ;
`endif
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DW-1:0] mem [2**AW];
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;

    // Writer and eraser always target different banks; INIT clears both at once.
    always_comb begin
      we = 1'b0;
      wa = init_cnt_q;
      wd = '0;
      if (state_q == INIT) begin
        we = 1'b1;
      end else if (s1_commit && s1_bank_q == 1'(gi)) begin
        we = 1'b1;
        wa = s1_addr_q;
        wd = s1_data_q;
      end else if (er_vld_q && er_bank_q == 1'(gi)) begin
        we = 1'b1;
        wa = er_addr_q;
      end
    end

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
    end

    assign ra          = (line_q == 1'(gi)) ? buf_addr : hdump[AW-1:0];
    assign bank_rd[gi] = mem[ra];
  end

endmodule

// File: tb/tb_jtcop_obj_linebuf.sv
// Scoreboard bench for jtcop_obj_linebuf: a per-bank pixel array model predicts every pxl_cen output.
`timescale 1ns/1ps
module tb_jtcop_obj_linebuf;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pxl_cen = 1'b0;
  logic          LHBL = 1'b1;
  logic [8:0]    hdump = '0;
  logic [AW-1:0] buf_addr = '0;
  logic [DW-1:0] buf_data = '0;
  logic          buf_we = 1'b0;
  logic          buf_rdy;
  logic          line;
  logic [DW-1:0] obj_pxl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [2][N];
  bit            m_line = 1'b0;
  bit            m_lhbl = 1'b1;
  int            init_left = N;
  int            last_a = 0;
  logic [DW-1:0] mon_e;

  jtcop_obj_linebuf #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .hdump    (hdump),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .buf_we   (buf_we),
    .buf_rdy  (buf_rdy),
    .line     (line),
    .obj_pxl  (obj_pxl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every pxl_cen edge produces one display sample, checked against the queue.
  always @(posedge clk) begin
    if (pxl_cen && !rst) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL obj_pxl_underflow: got 0x%0h with no expected entry at %0t", obj_pxl, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("obj_pxl", {24'd0, obj_pxl}, {24'd0, mon_e});
      end
    end
  end

  // One clk of stimulus; the model applies the same clk's effects from the behavioural rules.
  task automatic tick(input bit pce, input bit lh, input int h, input bit we, input int a,
                      input logic [DW-1:0] d);
    bit rdy_b;
    rdy_b    = (init_left == 0) && !rst;
    pxl_cen  = pce;
    LHBL     = lh;
    hdump    = 9'(h);
    buf_we   = we;
    buf_addr = AW'(a);
    buf_data = d;
    if (rst) begin
      m_line    = 1'b0;
      m_lhbl    = 1'b1;
      init_left = N;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) model[b][i] = '0;
    end else begin
      if (init_left > 0) init_left--;
      if (we && rdy_b && d[3:0] != 4'd0) begin
`ifdef JTCOP_OBJ_FIRSTWIN_EN
        if (model[m_line][a][3:0] == 4'd0) model[m_line][a] = d;
`else
        model[m_line][a] = d;
`endif
      end
      if (pce) begin
        if (lh && rdy_b) begin
          exp_q.push_back(model[m_line ^ 1'b1][h % N]);
          model[m_line ^ 1'b1][h % N] = '0;
        end else begin
          exp_q.push_back('0);
        end
        if (m_lhbl && !lh) m_line = m_line ^ 1'b1;
        m_lhbl = lh;
      end
    end
    @(posedge clk);
    #1;
    chk("buf_rdy", {31'd0, buf_rdy}, {31'd0, (init_left == 0) && !rst});
    chk("line", {31'd0, line}, {31'd0, m_line});
    if (rst) chk("obj_pxl_reset", {24'd0, obj_pxl}, 32'd0);
  endtask

  task automatic rtick(input bit pce, input bit lh, input int h, input bit wr);
    int a;
    logic [DW-1:0] d;
    a = ($urandom_range(0, 3) == 0) ? last_a : int'($urandom_range(0, N - 1));
    d = DW'($urandom);
    if ($urandom_range(0, 4) == 0) d[3:0] = 4'd0;
    last_a = a;
    tick(pce, lh, h, wr && ($urandom_range(0, 99) < 60), a, d);
  endtask

  // Blank (with the LHBL-fall swap on its first pxl_cen), then a full visible scan 0..N-1.
  task automatic do_line(input int nblank, input bit wr, input bit swap_wr, input int stop_h);
    logic [DW-1:0] d;
    d = {4'($urandom), 4'($urandom_range(1, 15))};
    tick(1'b1, 1'b0, 256, swap_wr, int'($urandom_range(0, N - 1)), d);
    rtick(1'b0, 1'b0, 256, wr);
    for (int b = 1; b < nblank; b++) begin
      rtick(1'b1, 1'b0, 256 + b, wr);
      rtick(1'b0, 1'b0, 256 + b, wr);
    end
    for (int h = 0; h < stop_h; h++) begin
      rtick(1'b1, 1'b1, h, wr);
      rtick(1'b0, 1'b1, h, wr);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 0, 1'b0, 0, '0);
    rst = 1'b0;
    // Writes during INIT must be ignored.
    repeat (N) rtick(1'b0, 1'b1, 0, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 0, 1'b0, 0, '0);

    tick(1'b0, 1'b1, 0, 1'b1, 10, 8'h85);
    tick(1'b0, 1'b1, 0, 1'b1, 20, 8'h40);
    tick(1'b0, 1'b1, 0, 1'b1, 30, 8'h13);
    tick(1'b0, 1'b1, 0, 1'b1, 30, 8'h27);
    tick(1'b0, 1'b1, 0, 1'b0, 0, '0);
    do_line(8, 1'b0, 1'b1, N);
    do_line(8, 1'b0, 1'b1, N);
    do_line(8, 1'b0, 1'b0, N);

    for (int l = 0; l < 6; l++) do_line(int'($urandom_range(2, 8)), 1'b1, 1'b1, N);

    // Reset in the middle of a visible line with writes in flight.
    do_line(6, 1'b1, 1'b1, 100);
    tick(1'b0, 1'b1, 100, 1'b1, 55, 8'h3C);
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b1, 100, 1'b1, 56, 8'h3D);
    rst = 1'b0;
    repeat (N) tick(1'b0, 1'b1, 0, 1'b0, 0, '0);
    do_line(8, 1'b0, 1'b0, N);
    do_line(8, 1'b0, 1'b0, N);
    for (int l = 0; l < 3; l++) do_line(int'($urandom_range(2, 8)), 1'b1, 1'b1, N);

    repeat (4) tick(1'b0, 1'b1, 0, 1'b0, 0, '0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
